// File: rtl/instruction_sequencer.sv
// Read-side controller for the firmware instruction ROM: fetches, decodes and issues
// CALC commands over valid/ready, waits for completion, and parks on HALT or a fault.
module instruction_sequencer #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 64,
   parameter int TIMEOUT = 1024,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [AW-1:0]    imem_addr,
   input  logic [WIDTH-1:0] imem_instruction,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic [WIDTH-5:0] cmd_operand,
   input  logic             calc_done,
   output logic             busy,
   output logic             halted,
   output logic             error,
   output logic [1:0]       err_code,
   output logic [15:0]      retired
);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_CALC = 4'h3;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_OVERRUN = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_HALTED, S_ERROR
   } state_t;

   state_t           state;
   logic [AW-1:0]    pc;
   logic [WIDTH-1:0] ir;
   logic [TW-1:0]    wait_count;
   logic [3:0]       opcode;
   logic [15:0]      retired_inc;
   logic             pc_last;
   logic             retire_now;

   assign opcode      = ir[WIDTH-1:WIDTH-4];
   assign retired_inc = (retired == 16'hFFFF) ? retired : retired + 16'd1;
   assign pc_last     = (pc == AW'(DEPTH - 1));
   assign imem_addr   = pc;

   // NOP in DECODE and a completion in WAIT share the same retire-and-advance path.
   assign retire_now  = (state == S_DECODE && opcode == OP_NOP) ||
                        (state == S_WAIT && calc_done);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         pc          <= '0;
         ir          <= '0;
         wait_count  <= '0;
         cmd_valid   <= 1'b0;
         cmd_operand <= '0;
         busy        <= 1'b0;
         halted      <= 1'b0;
         error       <= 1'b0;
         err_code    <= 2'b00;
         retired     <= 16'd0;
      end else if (retire_now) begin
         retired <= retired_inc;
         // The PC never wraps; stepping past the last word is a fault.
         if (pc_last) begin
            error    <= 1'b1;
            err_code <= ERR_OVERRUN;
            busy     <= 1'b0;
            state    <= S_ERROR;
         end else begin
            pc    <= pc + 1'b1;
            state <= S_FETCH;
         end
      end else begin
         case (state)
            S_IDLE, S_HALTED, S_ERROR: begin
               if (start) begin
                  pc       <= '0;
                  halted   <= 1'b0;
                  error    <= 1'b0;
                  err_code <= 2'b00;
                  retired  <= 16'd0;
                  busy     <= 1'b1;
                  state    <= S_FETCH;
               end
            end
            S_FETCH: begin
               ir    <= imem_instruction;
               state <= S_DECODE;
            end
            S_DECODE: begin
               if (opcode == OP_HALT) begin
                  retired <= retired_inc;
                  halted  <= 1'b1;
                  busy    <= 1'b0;
                  state   <= S_HALTED;
               end else if (opcode == OP_CALC) begin
                  cmd_operand <= ir[WIDTH-5:0];
                  cmd_valid   <= 1'b1;
                  state       <= S_ISSUE;
               end else begin
                  error    <= 1'b1;
                  err_code <= ERR_ILLEGAL;
                  busy     <= 1'b0;
                  state    <= S_ERROR;
               end
            end
            S_ISSUE: begin
               if (cmd_ready) begin
                  cmd_valid  <= 1'b0;
                  wait_count <= '0;
                  state      <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (wait_count == TW'(TIMEOUT - 1)) begin
                  error    <= 1'b1;
                  err_code <= ERR_TIMEOUT;
                  busy     <= 1'b0;
                  state    <= S_ERROR;
               end else begin
                  wait_count <= wait_count + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: an instruction-level reference model,
// a per-cycle compare process, directed scenarios and randomized programs.
module tb_instruction_sequencer;
   localparam int WIDTH   = 16;
   localparam int DEPTH   = 64;
   localparam int TIMEOUT = 16;
   localparam int AW      = $clog2(DEPTH);

   localparam int PH_FETCH  = 0;
   localparam int PH_DECODE = 1;
   localparam int PH_ISSUE  = 2;
   localparam int PH_WAIT   = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [AW-1:0]    imem_addr;
   logic [WIDTH-1:0] imem_instruction;
   logic             cmd_valid;
   logic             cmd_ready = 1'b0;
   logic [WIDTH-5:0] cmd_operand;
   logic             calc_done = 1'b0;
   logic             busy;
   logic             halted;
   logic             error;
   logic [1:0]       err_code;
   logic [15:0]      retired;

   logic [15:0] rom [DEPTH];

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   // Stimulus knobs and per-run observations.
   int ready_mode = 0;
   int ready_hold = 0;
   int done_delay = 0;
   int start_mode = 0;
   int first_valid_cycle, valid_cycles, handshakes, err_first_cycle;
   int cyc1_retired, cyc1_addr, cyc1_error;
   logic [11:0] last_operand;

   // Reference model state, advanced once per rising edge.
   int          m_pc = 0;
   int          m_phase = PH_FETCH;
   int          m_waited = 0;
   int          m_retired = 0;
   bit          m_busy = 1'b0;
   bit          m_halted = 1'b0;
   bit          m_error = 1'b0;
   bit          m_valid = 1'b0;
   logic [1:0]  m_code = 2'b00;
   logic [11:0] m_operand = 12'd0;
   logic [15:0] m_word;

   instruction_sequencer #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .imem_addr(imem_addr),
      .imem_instruction(imem_instruction),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_operand(cmd_operand),
      .calc_done(calc_done),
      .busy(busy),
      .halted(halted),
      .error(error),
      .err_code(err_code),
      .retired(retired)
   );

   assign imem_instruction = rom[imem_addr];

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic model_fault(input logic [1:0] code);
      m_error = 1'b1;
      m_code  = code;
      m_busy  = 1'b0;
   endtask

   task automatic model_retire();
      if (m_retired < 65535) m_retired++;
      if (m_pc == DEPTH - 1) model_fault(2'b10);
      else begin
         m_pc++;
         m_phase = PH_FETCH;
      end
   endtask

   // Instruction-level behaviour: what a program does, cycle by cycle.
   always @(posedge clk) begin
      if (rst) begin
         m_pc = 0; m_busy = 1'b0; m_halted = 1'b0; m_error = 1'b0; m_valid = 1'b0;
         m_code = 2'b00; m_retired = 0; m_operand = 12'd0; m_phase = PH_FETCH;
      end else if (!m_busy) begin
         if (start) begin
            m_pc = 0; m_halted = 1'b0; m_error = 1'b0; m_code = 2'b00;
            m_retired = 0; m_busy = 1'b1; m_phase = PH_FETCH;
         end
      end else begin
         case (m_phase)
            PH_FETCH: m_phase = PH_DECODE;
            PH_DECODE: begin
               m_word = rom[m_pc];
               if (m_word[15:12] == 4'h0) model_retire();
               else if (m_word[15:12] == 4'hF) begin
                  if (m_retired < 65535) m_retired++;
                  m_halted = 1'b1;
                  m_busy   = 1'b0;
               end else if (m_word[15:12] == 4'h3) begin
                  m_operand = m_word[11:0];
                  m_valid   = 1'b1;
                  m_phase   = PH_ISSUE;
               end else model_fault(2'b01);
            end
            PH_ISSUE: begin
               if (cmd_ready) begin
                  m_valid  = 1'b0;
                  m_waited = 0;
                  m_phase  = PH_WAIT;
               end
            end
            PH_WAIT: begin
               if (calc_done) model_retire();
               else begin
                  m_waited++;
                  if (m_waited == TIMEOUT) model_fault(2'b11);
               end
            end
            default: ;
         endcase
      end
   end

   // Every observed cycle the DUT must agree with the model.
   always @(negedge clk) begin
      if (check_en) begin
         check_output("imem_addr", 32'(imem_addr), 32'(m_pc));
         check_output("cmd_valid", 32'(cmd_valid), 32'(m_valid));
         check_output("cmd_operand", 32'(cmd_operand), 32'(m_operand));
         check_output("busy", 32'(busy), 32'(m_busy));
         check_output("halted", 32'(halted), 32'(m_halted));
         check_output("error", 32'(error), 32'(m_error));
         check_output("err_code", 32'(err_code), 32'(m_code));
         check_output("retired", 32'(retired), 32'(m_retired));
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b0; cmd_ready = 1'b0; calc_done = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic fill_rom(input logic [15:0] value);
      for (int i = 0; i < DEPTH; i++) rom[i] = value;
   endtask

   function automatic logic [15:0] random_word();
      int r = int'($urandom_range(99));
      logic [11:0] operand = 12'($urandom);
      logic [3:0] op;
      if (r < 35) op = 4'h0;
      else if (r < 70) op = 4'h3;
      else if (r < 85) op = 4'hF;
      else begin
         op = 4'($urandom_range(14, 1));
         if (op == 4'h3) op = 4'h9;
      end
      return {op, operand};
   endfunction

   // Pulses start, then drives ready/done/start each cycle until the model parks.
   task automatic apply_stimulus(input int budget);
      int n;
      int vcount;
      bit finished;
      first_valid_cycle = -1; valid_cycles = 0; handshakes = 0; err_first_cycle = -1;
      vcount = 0; n = 0; finished = 1'b0;
      @(negedge clk);
      start = 1'b1;
      calc_done = 1'b0;
      cmd_ready = (ready_mode == 0);
      while (!finished) begin
         @(negedge clk);
         n++;
         if (cmd_valid) begin
            if (first_valid_cycle < 0) first_valid_cycle = n;
            valid_cycles++;
            last_operand = cmd_operand;
         end
         if (error && err_first_cycle < 0) err_first_cycle = n;
         if (n == 1) begin
            cyc1_retired = int'(retired); cyc1_addr = int'(imem_addr); cyc1_error = int'(error);
         end
         if (!m_busy) finished = 1'b1;
         else if (n >= budget) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL run_budget: still busy after %0d cycles, required parked", n);
            finished = 1'b1;
         end else begin
            start = (start_mode == 1 && $urandom_range(3) == 0) ||
                    (start_mode == 2 && m_phase == PH_WAIT);
            case (ready_mode)
               0: cmd_ready = 1'b1;
               1: cmd_ready = 1'($urandom_range(1));
               default: begin
                  if (m_valid) begin
                     cmd_ready = (vcount >= ready_hold);
                     vcount++;
                  end else begin
                     cmd_ready = 1'b0;
                     vcount = 0;
                  end
               end
            endcase
            if (done_delay == -2) calc_done = ($urandom_range(7) == 0);
            else if (done_delay < 0) calc_done = 1'b0;
            else calc_done = (m_phase == PH_WAIT && m_waited == done_delay);
            if (cmd_valid && cmd_ready) handshakes++;
         end
      end
      start = 1'b0;
      calc_done = 1'b0;
   endtask

   initial begin
      fill_rom(16'hF000);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_en = 1'b1;
      check_output("reset_addr", 32'(imem_addr), 32'd0);
      check_output("reset_valid", 32'(cmd_valid), 32'd0);
      check_output("reset_busy", 32'(busy), 32'd0);
      check_output("reset_retired", 32'(retired), 32'd0);

      // CALC then HALT, ready tied high, completion on the fifth WAIT cycle.
      fill_rom(16'hF000);
      rom[0] = 16'h3003; rom[1] = 16'hF000;
      ready_mode = 0; done_delay = 4; start_mode = 0;
      apply_stimulus(200);
      check_output("t1_first_valid_cycle", 32'(first_valid_cycle), 32'd3);
      check_output("t1_operand", 32'(last_operand), 32'h003);
      check_output("t1_handshakes", 32'(handshakes), 32'd1);
      check_output("t1_halted", 32'(halted), 32'd1);
      check_output("t1_retired", 32'(retired), 32'd2);
      check_output("t1_addr", 32'(imem_addr), 32'd1);
      check_output("t1_error", 32'(error), 32'd0);

      // Back-pressure: ready low for the first four valid cycles.
      do_reset();
      rom[0] = 16'h0000; rom[1] = 16'h3ABC; rom[2] = 16'hF000;
      ready_mode = 2; ready_hold = 4; done_delay = 2;
      apply_stimulus(200);
      check_output("t2_valid_cycles", 32'(valid_cycles), 32'd5);
      check_output("t2_handshakes", 32'(handshakes), 32'd1);
      check_output("t2_operand", 32'(last_operand), 32'hABC);
      check_output("t2_retired", 32'(retired), 32'd3);

      // Illegal opcode.
      fill_rom(16'hF000);
      rom[0] = 16'h7123;
      ready_mode = 0; done_delay = 0;
      apply_stimulus(200);
      check_output("t3_error", 32'(error), 32'd1);
      check_output("t3_err_code", 32'(err_code), 32'd1);
      check_output("t3_valid_cycles", 32'(valid_cycles), 32'd0);
      check_output("t3_busy", 32'(busy), 32'd0);

      // All NOPs run off the end of the ROM.
      fill_rom(16'h0000);
      apply_stimulus(400);
      check_output("t4_err_code", 32'(err_code), 32'd2);
      check_output("t4_addr", 32'(imem_addr), 32'd63);
      check_output("t4_retired", 32'(retired), 32'd64);

      // Completion never arrives; ERROR is entered TIMEOUT cycles after WAIT entry (cycle 4).
      fill_rom(16'hF000);
      rom[0] = 16'h3005; rom[1] = 16'hF000;
      ready_mode = 0; done_delay = -1;
      apply_stimulus(200);
      check_output("t5_restart_retired", 32'(cyc1_retired), 32'd0);
      check_output("t5_restart_addr", 32'(cyc1_addr), 32'd0);
      check_output("t5_restart_error", 32'(cyc1_error), 32'd0);
      check_output("t5_err_code", 32'(err_code), 32'd3);
      check_output("t5_err_cycle", 32'(err_first_cycle), 32'd20);
      check_output("t5_retired", 32'(retired), 32'd0);
      done_delay = 3;
      apply_stimulus(200);
      check_output("t5_rerun_halted", 32'(halted), 32'd1);
      check_output("t5_rerun_retired", 32'(retired), 32'd2);
      check_output("t5_rerun_error", 32'(error), 32'd0);

      // Reset while a command is pending; it must not come back.
      do_reset();
      rom[0] = 16'h3111; rom[1] = 16'hF000;
      @(negedge clk); start = 1'b1; cmd_ready = 1'b0;
      @(negedge clk); start = 1'b0;
      repeat (2) @(negedge clk);
      check_output("t6_pending_valid", 32'(cmd_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_output("t6_rst_valid", 32'(cmd_valid), 32'd0);
      check_output("t6_rst_operand", 32'(cmd_operand), 32'd0);
      check_output("t6_rst_busy", 32'(busy), 32'd0);
      check_output("t6_rst_addr", 32'(imem_addr), 32'd0);
      cmd_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_output("t6_no_reissue", 32'(cmd_valid), 32'd0);
      end

      // start held throughout WAIT is ignored.
      rom[0] = 16'h3222; rom[1] = 16'hF000;
      ready_mode = 0; done_delay = 6; start_mode = 2;
      apply_stimulus(200);
      check_output("t7_handshakes", 32'(handshakes), 32'd1);
      check_output("t7_addr", 32'(imem_addr), 32'd1);
      check_output("t7_retired", 32'(retired), 32'd2);
      check_output("t7_halted", 32'(halted), 32'd1);

      // Randomized programs, back-pressure, stray completions and start pulses.
      for (int it = 0; it < 24; it++) begin
         for (int i = 0; i < DEPTH; i++) rom[i] = random_word();
         ready_mode = int'($urandom_range(1));
         done_delay = -2;
         start_mode = int'($urandom_range(1));
         if (it % 6 == 0) do_reset();
         apply_stimulus(3000);
      end

      check_en = 1'b0;
      $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
